// File: rtl/load_store_unit.sv
// load_store_unit: converts RISC-V byte-addressed loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW)
// into word accesses on a word-addressed data RAM (combinational read, write on posedge).
// Sub-word stores are done as read-modify-write. One transaction in flight.
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   -> misaligned H/HU/SH/W/SW requests return resp_error without touching memory
//   undefined -> low address bits are forced to natural alignment and the access proceeds
module load_store_unit #(
  parameter int MEMORY_SIZE = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int AW = $clog2(MEMORY_SIZE / 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Transaction context captured on accept
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;

  // Registered outputs
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_error;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_write_data;

  logic        w_idle_ready;
  logic        w_accept;
  logic        w_f3_ok;
  logic        w_range_err;
  logic        w_misalign;
  logic        w_req_err;
  logic [1:0]  w_lane;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;
  logic [31:0] w_ins;
  logic [3:0]  w_byte_en;
  logic [31:0] w_merged;

  assign w_idle_ready = reset && (r_state == S_IDLE);
  assign w_accept     = req_valid && w_idle_ready;
  assign req_ready    = w_idle_ready;

  // Request decode: legal funct3 per direction, range and (optionally) alignment
  always_comb begin
    w_f3_ok = 1'b0;
    if (req_write) begin
      // only SB/SH/SW are meaningful stores; everything else is rejected
      w_f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      w_f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
  end

  assign w_range_err = (req_address >= 32'(MEMORY_SIZE));

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_address[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_address[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_err = !w_f3_ok || w_range_err || w_misalign;

  // Lane within the word after forcing natural alignment (a no-op when misalignment is an error)
  always_comb begin
    w_lane = req_address[1:0];
    if (req_funct3[1:0] == 2'b01) begin
      w_lane = {req_address[1], 1'b0};
    end else if (req_funct3[1:0] == 2'b10) begin
      w_lane = 2'b00;
    end
  end

  // Load path: move the addressed lane down to bit 0, then sign/zero extend
  assign w_shifted = mem_read_data >> {r_lane, 3'b000};

  always_comb begin
    w_load_data = mem_read_data;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b100:  w_load_data = {24'h0, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b101:  w_load_data = {16'h0, w_shifted[15:0]};
      default: w_load_data = mem_read_data;
    endcase
  end

  // Sub-word store merge: replicated store data plus per-byte enables over the read word
  assign w_ins = (r_funct3[1:0] == 2'b00) ? {4{r_wdata[7:0]}} : {2{r_wdata}};

  always_comb begin
    w_byte_en = 4'b0000;
    if (r_funct3[1:0] == 2'b00) begin
      w_byte_en = 4'b0001 << r_lane;
    end else begin
      w_byte_en = r_lane[1] ? 4'b1100 : 4'b0011;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign w_merged[8*gi +: 8] = w_byte_en[gi] ? w_ins[8*gi +: 8] : mem_read_data[8*gi +: 8];
    end
  endgenerate

  // Next-state and memory strobes; strobes depend on state only and are gated by reset
  always_comb begin
    w_state_next = r_state;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_state_next = S_DONE;
          end else if (!req_write) begin
            w_state_next = S_LOAD;
          end else if (req_funct3[1:0] == 2'b10) begin
            w_state_next = S_STORE;
          end else begin
            w_state_next = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        mem_read     = reset;
        w_state_next = S_DONE;
      end
      S_STORE: begin
        mem_write    = reset;
        w_state_next = S_DONE;
      end
      S_RMW_RD: begin
        mem_read     = reset;
        w_state_next = S_RMW_WR;
      end
      S_RMW_WR: begin
        mem_write    = reset;
        w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register, captured request context and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_funct3         <= 3'b000;
      r_lane           <= 2'b00;
      r_wdata          <= 16'h0;
      r_resp_valid     <= 1'b0;
      r_resp_rdata     <= 32'h0;
      r_resp_error     <= 1'b0;
      r_mem_address    <= 32'h0;
      r_mem_write_data <= 32'h0;
    end else begin
      r_state      <= w_state_next;
      r_resp_valid <= (w_state_next == S_DONE);
      if (w_accept) begin
        r_funct3     <= req_funct3;
        r_lane       <= w_lane;
        r_wdata      <= req_wdata[15:0];
        r_resp_rdata <= 32'h0;
        r_resp_error <= w_req_err;
        if (!w_req_err) begin
          r_mem_address <= {{(32 - AW){1'b0}}, req_address[AW+1:2]};
          if (req_write) begin
            r_mem_write_data <= req_wdata;
          end
        end
      end
      if (r_state == S_LOAD) begin
        r_resp_rdata <= w_load_data;
      end
      if (r_state == S_RMW_RD) begin
        r_mem_write_data <= w_merged;
      end
    end
  end

  assign resp_valid     = r_resp_valid;
  assign resp_rdata     = r_resp_rdata;
  assign resp_error     = r_resp_error;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_write_data;

endmodule
